// File: rtl/noc_inj_pkg.sv
// Shared definitions for the NoC packet injector: header field positions, FSM
// encoding and the LFSR feedback mask used when NOC_INJ_LFSR_EN is defined.
package noc_inj_pkg;

  localparam int HDR_CHIPID_LSB = 50;
  localparam int HDR_XPOS_LSB   = 42;
  localparam int HDR_YPOS_LSB   = 34;
  localparam int HDR_FBITS_LSB  = 30;
  localparam int HDR_PLEN_LSB   = 22;
  localparam int HDR_TYPE_LSB   = 14;
  localparam int HDR_TAG_LSB    = 6;

  localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } inj_state_e;

  // Header layout matches what the tracing monitor decodes; bits [5:0] stay zero.
  function automatic logic [63:0] build_header(
    input logic [13:0] chipid,
    input logic [7:0]  xpos,
    input logic [7:0]  ypos,
    input logic [3:0]  fbits,
    input logic [7:0]  plen,
    input logic [7:0]  msg_type,
    input logic [7:0]  tag
  );
    logic [63:0] h;
    h = '0;
    h[HDR_CHIPID_LSB +: 14] = chipid;
    h[HDR_XPOS_LSB   +: 8]  = xpos;
    h[HDR_YPOS_LSB   +: 8]  = ypos;
    h[HDR_FBITS_LSB  +: 4]  = fbits;
    h[HDR_PLEN_LSB   +: 8]  = plen;
    h[HDR_TYPE_LSB   +: 8]  = msg_type;
    h[HDR_TAG_LSB    +: 8]  = tag;
    return h;
  endfunction

endpackage

// File: rtl/noc_inj_pattern_gen.sv
// Payload pattern source: incrementing counter by default, 64-bit Galois LFSR
// when NOC_INJ_LFSR_EN is defined. o_word always holds the next flit to send.
module noc_inj_pattern_gen
  import noc_inj_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [63:0] i_seed,
  input  logic        i_advance,
  output logic [63:0] o_word
);

  logic [63:0] r_word;
  logic [63:0] w_next;
  logic [63:0] w_load_val;

`ifdef NOC_INJ_LFSR_EN
  // A zero state would lock the LFSR, so a zero seed starts from 1 instead.
  assign w_load_val = (i_seed == 64'd0) ? 64'd1 : i_seed;
  assign w_next     = (r_word >> 1) ^ (r_word[0] ? LFSR_MASK : 64'd0);
`else
  assign w_load_val = i_seed;
  assign w_next     = r_word + 64'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
    end else if (i_load) begin
      r_word <= w_load_val;
    end else if (i_advance) begin
      r_word <= w_next;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/noc_packet_injector_vr.sv
// NoC packet injector: serializes one descriptor into a header flit plus plen
// payload flits on a valid/ready link. Payload pattern selected by NOC_INJ_LFSR_EN.
module noc_packet_injector_vr
  import noc_inj_pkg::*;
#(
  parameter int PKT_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_val,
  output logic                 cmd_rdy,
  input  logic [13:0]          cmd_chipid,
  input  logic [7:0]           cmd_xpos,
  input  logic [7:0]           cmd_ypos,
  input  logic [3:0]           cmd_fbits,
  input  logic [7:0]           cmd_plen,
  input  logic [7:0]           cmd_msg_type,
  input  logic [7:0]           cmd_tag,
  input  logic [63:0]          cmd_seed,
  output logic [63:0]          dout_msg,
  output logic                 dout_val,
  input  logic                 dout_rdy,
  output logic                 busy,
  output logic [PKT_CNT_W-1:0] pkt_count
);

  inj_state_e           r_state;
  inj_state_e           w_state_nxt;
  logic [7:0]           r_cnt;
  logic [7:0]           w_cnt_nxt;
  logic [63:0]          r_msg;
  logic [63:0]          w_msg_nxt;
  logic                 r_val;
  logic                 w_val_nxt;
  logic [PKT_CNT_W-1:0] r_pkt_count;

  logic        w_accept;
  logic        w_xfer;
  logic        w_pat_load;
  logic        w_pat_advance;
  logic        w_pkt_done;
  logic [63:0] w_pat_word;
  logic [63:0] w_hdr;

  assign w_accept = cmd_val & cmd_rdy;
  assign w_xfer   = r_val & dout_rdy;
  assign w_hdr    = build_header(cmd_chipid, cmd_xpos, cmd_ypos, cmd_fbits,
                                 cmd_plen, cmd_msg_type, cmd_tag);

  noc_inj_pattern_gen u_pattern (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_pat_load),
    .i_seed    (cmd_seed),
    .i_advance (w_pat_advance),
    .o_word    (w_pat_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_msg       <= '0;
      r_val       <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_msg   <= w_msg_nxt;
      r_val   <= w_val_nxt;
      if (w_pkt_done) begin
        r_pkt_count <= r_pkt_count + PKT_CNT_W'(1);
      end
    end
  end

  // The pattern generator runs one flit ahead, so each accept loads the
  // output register with its current word and steps it to the following one.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_msg_nxt     = r_msg;
    w_val_nxt     = r_val;
    w_pat_load    = 1'b0;
    w_pat_advance = 1'b0;
    w_pkt_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_HDR;
          w_cnt_nxt   = cmd_plen;
          w_msg_nxt   = w_hdr;
          w_val_nxt   = 1'b1;
          w_pat_load  = 1'b1;
        end
      end
      ST_HDR: begin
        if (w_xfer) begin
          if (r_cnt == 8'd0) begin
            w_state_nxt = ST_IDLE;
            w_msg_nxt   = '0;
            w_val_nxt   = 1'b0;
            w_pkt_done  = 1'b1;
          end else begin
            w_state_nxt   = ST_PAY;
            w_msg_nxt     = w_pat_word;
            w_pat_advance = 1'b1;
          end
        end
      end
      ST_PAY: begin
        if (w_xfer) begin
          w_cnt_nxt = r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            w_state_nxt = ST_IDLE;
            w_msg_nxt   = '0;
            w_val_nxt   = 1'b0;
            w_pkt_done  = 1'b1;
          end else begin
            w_msg_nxt     = w_pat_word;
            w_pat_advance = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_val_nxt   = 1'b0;
        w_msg_nxt   = '0;
      end
    endcase
  end

  assign cmd_rdy   = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign dout_msg  = r_msg;
  assign dout_val  = r_val;
  assign pkt_count = r_pkt_count;

endmodule
